// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS fetch stage
package mips_fetch_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 26;
    localparam int          PC_INC           = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_reg.sv
// rtl/fetch_skid_reg.sv - two-entry (decode register + skid) valid/ready buffer with flush
module fetch_skid_reg
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              skid_full
);

    logic              id_valid_q, id_valid_d;
    logic [DATA_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              consume;

    always_comb begin
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        consume      = id_valid_q && out_ready;

        if (flush) begin
            id_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (consume) begin
                id_valid_d   = skid_valid_q;
                skid_valid_d = 1'b0;
                if (skid_valid_q) begin
                    id_instr_d = skid_instr_q;
                    id_pc_d    = skid_pc_q;
                end
            end
            // id_valid_d already reflects this cycle's consume/refill
            if (in_valid) begin
                if (!id_valid_d) begin
                    id_valid_d = 1'b1;
                    id_instr_d = in_instr;
                    id_pc_d    = in_pc;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= DATA_W'(NOP_INSTR);
            id_pc_q      <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= DATA_W'(NOP_INSTR);
            skid_pc_q    <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_valid = id_valid_q;
    assign out_instr = id_instr_q;
    assign out_pc    = id_pc_q;
    assign skid_full = skid_valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, single-outstanding imem requests, decode buffer
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [5:0]        id_opcode,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic              skid_full;
    logic              grant;
    logic              accept;
    logic              resp_owed;

    // A stale response is still owed while drop is set, so no new request may issue
    assign imem_req  = (state_q == ST_REQ) && !skid_full && !drop_q && !reset;
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    assign accept    = (state_q == ST_WAIT) && imem_rvalid && !drop_q && !redirect && !reset;
    assign resp_owed = ((state_q == ST_WAIT) || drop_q) && !imem_rvalid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;

        case (state_q)
            ST_REQ: begin
                if (drop_q && imem_rvalid) begin
                    drop_d = 1'b0;
                end else if (grant) begin
                    req_pc_d = pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        pc_d = req_pc_q + ADDR_W'(PC_INC);
                    end
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect) begin
            pc_d    = redirect_pc & ~ADDR_W'(3);
            state_d = ST_REQ;
            drop_d  = resp_owed || grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= resp_owed;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    fetch_skid_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .in_valid  (accept),
        .in_instr  (imem_rdata),
        .in_pc     (req_pc_q),
        .out_valid (id_valid),
        .out_ready (id_ready),
        .out_instr (id_instr),
        .out_pc    (id_pc),
        .skid_full (skid_full)
    );

    assign id_opcode   = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_pc_plus4 = id_pc + ADDR_W'(PC_INC);

endmodule
